// File: rtl/cv_pkg.sv
// Shared constants, FSM encoding and note-to-code helper
// for the CV glide generator (semitone -> 12-bit 1V/oct DAC code).
package cv_pkg;

  localparam logic [1:0]  MODE_NORMAL = 2'b00;
  localparam logic [1:0]  MODE_PD1K   = 2'b01;
  localparam int          SEMI_SCALE  = 273;
  localparam int          SEMI_SHIFT  = 2;
  localparam logic [11:0] DAC_MAX     = 12'd4095;

  typedef enum logic {
    HOLD = 1'b0,
    SLEW = 1'b1
  } glide_state_e;

  // 1V/oct on a 4096-code / 5 V span: 273/4 codes per semitone
  function automatic logic [11:0] note2code(input logic [5:0] n);
    logic [14:0] p;
    p = 15'(n) * 15'(SEMI_SCALE);
    return 12'(p >> SEMI_SHIFT);
  endfunction

endpackage

// File: rtl/slew_tick_gen.sv
// Slew timebase: free-running base prescaler plus rate divider.
// Ports: clk, rst, glide_rate_i[3:0] -> slew_tick_o (1-cycle pulse).
module slew_tick_gen #(
  parameter int PRESCALE = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] glide_rate_i,
  output logic       slew_tick_o
);

  localparam int BW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [BW-1:0] base_q, base_d;
  logic [3:0]    rate_q, rate_d;
  logic          base_tick;

  assign base_tick = (base_q == BW'(PRESCALE - 1));

  always_comb begin
    base_d      = base_tick ? '0 : base_q + 1'b1;
    rate_d      = rate_q;
    slew_tick_o = 1'b0;
    if (base_tick) begin
      // rate is sampled live; a lowered rate waits for the 4-bit wrap
      if (rate_q == glide_rate_i) begin
        rate_d      = '0;
        slew_tick_o = 1'b1;
      end else begin
        rate_d = rate_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      rate_q <= '0;
    end else begin
      base_q <= base_d;
      rate_q <= rate_d;
    end
  end

endmodule

// File: rtl/cv_glide_generator.sv
// Converts sequencer notes to DAC codes with optional portamento
// and gate-driven mute. Ports: clk, rst, note_i/note_valid_i,
// glide_en_i, glide_rate_i, gate_i, mute_en_i -> data_o, mode_o,
// enable_o, target_o, busy_o.
module cv_glide_generator
  import cv_pkg::*;
#(
  parameter int PRESCALE = 500,
  parameter int STEP     = 4,
  parameter int NOTE_MAX = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  note_i,
  input  logic        note_valid_i,
  input  logic        glide_en_i,
  input  logic [3:0]  glide_rate_i,
  input  logic        gate_i,
  input  logic        mute_en_i,
  output logic [11:0] data_o,
  output logic [1:0]  mode_o,
  output logic        enable_o,
  output logic [11:0] target_o,
  output logic        busy_o
);

  glide_state_e state_q, state_d;
  logic [11:0]  data_q, data_d;
  logic [11:0]  target_q, target_d;
  logic         jump_q, jump_d;
  logic [1:0]   mode_q, mode_d;
  logic         enable_q;
  logic         slew_tick;
  logic [5:0]   n_c;
  logic [11:0]  tgt_new;
  logic [11:0]  stepped;

  slew_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk          (clk),
    .rst          (rst),
    .glide_rate_i (glide_rate_i),
    .slew_tick_o  (slew_tick)
  );

  assign n_c     = (note_i > 6'(NOTE_MAX)) ? 6'(NOTE_MAX) : note_i;
  assign tgt_new = note2code(n_c);

  // step toward target, comparing distance first so no wrap can occur
  always_comb begin
    stepped = target_q;
    if (target_q > data_q) begin
      if ((target_q - data_q) > 12'(STEP))
        stepped = data_q + 12'(STEP);
    end else if (data_q > target_q) begin
      if ((data_q - target_q) > 12'(STEP))
        stepped = data_q - 12'(STEP);
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    target_d = target_q;
    jump_d   = 1'b0;
    mode_d   = (mute_en_i & ~gate_i) ? MODE_PD1K : MODE_NORMAL;
    if (jump_q) begin
      data_d = target_q;
    end else if (state_q == SLEW && slew_tick) begin
      // a coincident strobe still sees this step applied to the old target
      data_d = stepped;
      if (stepped == target_q)
        state_d = HOLD;
    end
    if (note_valid_i) begin
      target_d = tgt_new;
      if (glide_en_i) begin
        state_d = (tgt_new != data_d) ? SLEW : HOLD;
      end else begin
        state_d = HOLD;
        jump_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HOLD;
      data_q   <= '0;
      target_q <= '0;
      jump_q   <= 1'b0;
      mode_q   <= MODE_NORMAL;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      target_q <= target_d;
      jump_q   <= jump_d;
      mode_q   <= mode_d;
      enable_q <= 1'b1;
    end
  end

  assign data_o   = data_q;
  assign target_o = target_q;
  assign mode_o   = mode_q;
  assign enable_o = enable_q;
  assign busy_o   = (state_q == SLEW);

endmodule
